// File: rtl/text_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_display_pkg
// Description : Character codes and scroll FSM states shared by the
//               multi-digit text display.
// Revision    : 1.0 - initial release
// ============================================================================
package text_display_pkg;

    localparam logic [4:0] CH_HYPHEN   = 5'd0;
    localparam logic [4:0] CH_A        = 5'd1;
    localparam logic [4:0] CH_Z        = 5'd26;
    localparam logic [4:0] CH_UNDERBAR = 5'd27;
    localparam logic [4:0] CH_BLANK    = 5'd31;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        PAUSE  = 2'd2
    } state_t;

endpackage : text_display_pkg
`default_nettype wire

// File: rtl/glyph_decode.sv
`default_nettype none
// ============================================================================
// Module      : glyph_decode
// Description : Combinational 5-bit character code to seven-segment glyph,
//               segment order {a,b,c,d,e,f,g}, active-high.
// Revision    : 1.0 - initial release
// ============================================================================
module glyph_decode
    import text_display_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b0000000;
        case (code)
            CH_HYPHEN:   seg = 7'b0000001;
            CH_A:        seg = 7'b1110111;
            5'd2:        seg = 7'b0011111;
            5'd3:        seg = 7'b1001110;
            5'd4:        seg = 7'b0111101;
            5'd5:        seg = 7'b1001111;
            5'd6:        seg = 7'b1000111;
            5'd7:        seg = 7'b1011110;
            5'd8:        seg = 7'b0110111;
            5'd9:        seg = 7'b0110000;
            5'd10:       seg = 7'b0111100;
            5'd11:       seg = 7'b1010111;
            5'd12:       seg = 7'b0001110;
            5'd13:       seg = 7'b1010100;
            5'd14:       seg = 7'b0010101;
            5'd15:       seg = 7'b0011101;
            5'd16:       seg = 7'b1100111;
            5'd17:       seg = 7'b1110011;
            5'd18:       seg = 7'b0000101;
            5'd19:       seg = 7'b1011011;
            5'd20:       seg = 7'b0001111;
            5'd21:       seg = 7'b0111110;
            5'd22:       seg = 7'b0011100;
            5'd23:       seg = 7'b0101010;
            5'd24:       seg = 7'b1001001;
            5'd25:       seg = 7'b0111011;
            CH_Z:        seg = 7'b1101101;
            CH_UNDERBAR: seg = 7'b0001000;
            default:     seg = 7'b0000000;
        endcase
    end

endmodule : glyph_decode
`default_nettype wire

// File: rtl/scroll_text_display.sv
`default_nettype none
// ============================================================================
// Module      : scroll_text_display
// Description : Message buffer driving a time-multiplexed NUM_DIGITS
//               seven-segment display, with optional right-to-left scrolling.
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_text_display
    import text_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int MSG_DEPTH   = 16,
    parameter int REFRESH_DIV = 50000,
    parameter int SCROLL_DIV  = 25000000,
    parameter int PAUSE_TICKS = 2,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [$clog2(MSG_DEPTH)-1:0]   wr_addr,
    input  logic [4:0]                     wr_char,
    input  logic [$clog2(MSG_DEPTH):0]     msg_len,
    input  logic                           start,
    input  logic                           stop,
    output logic [6:0]                     seg,
    output logic [NUM_DIGITS-1:0]          dig_en,
    output logic                           busy,
    output logic                           wrap_pulse
);

    localparam int c_AW = $clog2(MSG_DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_RW = $clog2(REFRESH_DIV + 1);
    localparam int c_SW = $clog2(SCROLL_DIV + 1);
    localparam int c_PW = $clog2(PAUSE_TICKS + 2);

    localparam logic [c_LW-1:0]       c_DEPTH   = c_LW'(MSG_DEPTH);
    localparam logic [6:0]            c_SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] c_DIG_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

    logic [4:0]            r_buf [MSG_DEPTH];
    logic [c_RW-1:0]       r_ref_cnt;
    logic [c_DW-1:0]       r_dig_idx;
    state_t                r_state,  w_state_nxt;
    logic [c_LW-1:0]       r_offset, w_offset_nxt;
    logic [c_LW-1:0]       r_len,    w_len_nxt;
    logic [c_SW-1:0]       r_scnt,   w_scnt_nxt;
    logic [c_PW-1:0]       r_pcnt,   w_pcnt_nxt;
    logic                  r_wrap,   w_wrap_nxt;
    logic [c_LW-1:0]       w_len_clamp;
    logic                  w_step;
    logic [c_LW-1:0]       w_sum;
    logic [4:0]            w_char;
    logic [6:0]            w_glyph;
    logic [NUM_DIGITS-1:0] w_dig_onehot;

    // ------------------------------------------------------------------
    // Message buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                r_buf[i] <= CH_BLANK;
            end
        end else if (wr_en) begin
            r_buf[wr_addr] <= wr_char;
        end
    end

    // ------------------------------------------------------------------
    // Digit refresh, free-running from reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_cnt <= '0;
            r_dig_idx <= '0;
        end else if (r_ref_cnt == c_RW'(REFRESH_DIV - 1)) begin
            r_ref_cnt <= '0;
            r_dig_idx <= (r_dig_idx == c_DW'(NUM_DIGITS - 1)) ? '0 : r_dig_idx + c_DW'(1);
        end else begin
            r_ref_cnt <= r_ref_cnt + c_RW'(1);
        end
    end

    // (offset + digit) mod len: the sum never exceeds len by more than
    // NUM_DIGITS-1 multiples, so a bounded subtract chain is enough.
    always_comb begin
        w_sum = r_offset + c_LW'(r_dig_idx);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_sum >= r_len) begin
                w_sum = w_sum - r_len;
            end
        end
    end

    assign w_char = ((r_len == '0) || w_sum[c_AW]) ? CH_BLANK : r_buf[w_sum[c_AW-1:0]];

    glyph_decode u_glyph_decode (
        .code (w_char),
        .seg  (w_glyph)
    );

    assign w_dig_onehot = NUM_DIGITS'(1) << r_dig_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg    <= c_SEG_OFF;
            dig_en <= c_DIG_OFF;
        end else begin
            seg    <= (ACTIVE_LOW != 0) ? ~w_glyph      : w_glyph;
            dig_en <= (ACTIVE_LOW != 0) ? ~w_dig_onehot : w_dig_onehot;
        end
    end

    // ------------------------------------------------------------------
    // Scroll FSM
    // ------------------------------------------------------------------
    assign w_len_clamp = (msg_len > c_DEPTH) ? c_DEPTH : msg_len;
    assign w_step      = (r_scnt == c_SW'(SCROLL_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_offset <= '0;
            r_len    <= '0;
            r_scnt   <= '0;
            r_pcnt   <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_offset <= w_offset_nxt;
            r_len    <= w_len_nxt;
            r_scnt   <= w_scnt_nxt;
            r_pcnt   <= w_pcnt_nxt;
            r_wrap   <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_len_nxt    = r_len;
        w_scnt_nxt   = r_scnt;
        w_pcnt_nxt   = r_pcnt;
        w_wrap_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                w_offset_nxt = '0;
                w_scnt_nxt   = '0;
                w_len_nxt    = w_len_clamp;
                if (start && (msg_len != '0)) begin
                    w_state_nxt = SCROLL;
                end
            end
            SCROLL: begin
                if (w_step) begin
                    w_scnt_nxt = '0;
                    if ((r_offset + c_LW'(1)) == r_len) begin
                        w_offset_nxt = '0;
                        w_wrap_nxt   = 1'b1;
                        w_pcnt_nxt   = '0;
                        w_state_nxt  = PAUSE;
                    end else begin
                        w_offset_nxt = r_offset + c_LW'(1);
                    end
                end else begin
                    w_scnt_nxt = r_scnt + c_SW'(1);
                end
            end
            PAUSE: begin
                w_offset_nxt = '0;
                if (PAUSE_TICKS == 0) begin
                    w_scnt_nxt  = '0;
                    w_state_nxt = SCROLL;
                end else if (w_step) begin
                    w_scnt_nxt = '0;
                    if ((32'(r_pcnt) + 32'd1) == 32'(PAUSE_TICKS)) begin
                        w_state_nxt = SCROLL;
                    end else begin
                        w_pcnt_nxt = r_pcnt + c_PW'(1);
                    end
                end else begin
                    w_scnt_nxt = r_scnt + c_SW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // stop overrides everything, including a simultaneous start
        if (stop) begin
            w_state_nxt  = IDLE;
            w_offset_nxt = '0;
            w_scnt_nxt   = '0;
            w_wrap_nxt   = 1'b0;
        end
    end

    assign busy       = (r_state != IDLE);
    assign wrap_pulse = r_wrap;

endmodule : scroll_text_display
`default_nettype wire

// File: tb/tb_scroll_text_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_scroll_text_display
// Description : Self-checking bench; a behavioural display model is compared
//               against an active-high and an active-low build every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scroll_text_display;

    localparam int N  = 4;
    localparam int D  = 16;
    localparam int RD = 4;
    localparam int SD = 8;
    localparam int PT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [4:0] wr_char = '0;
    logic [4:0] msg_len = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;

    logic [6:0] seg, seg_n;
    logic [3:0] dig_en, dig_n;
    logic       busy, busy_n, wrap_pulse, wrap_n;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scroll_text_display #(
        .NUM_DIGITS(N), .MSG_DEPTH(D), .REFRESH_DIV(RD),
        .SCROLL_DIV(SD), .PAUSE_TICKS(PT), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .msg_len(msg_len), .start(start), .stop(stop),
        .seg(seg), .dig_en(dig_en), .busy(busy), .wrap_pulse(wrap_pulse)
    );

    scroll_text_display #(
        .NUM_DIGITS(N), .MSG_DEPTH(D), .REFRESH_DIV(RD),
        .SCROLL_DIV(SD), .PAUSE_TICKS(PT), .ACTIVE_LOW(1)
    ) dut_n (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .msg_len(msg_len), .start(start), .stop(stop),
        .seg(seg_n), .dig_en(dig_n), .busy(busy_n), .wrap_pulse(wrap_n)
    );

    function automatic logic [6:0] ref_glyph(input int c);
        case (c)
            0: return 7'b0000001;   1: return 7'b1110111;   2: return 7'b0011111;
            3: return 7'b1001110;   4: return 7'b0111101;   5: return 7'b1001111;
            6: return 7'b1000111;   7: return 7'b1011110;   8: return 7'b0110111;
            9: return 7'b0110000;  10: return 7'b0111100;  11: return 7'b1010111;
           12: return 7'b0001110;  13: return 7'b1010100;  14: return 7'b0010101;
           15: return 7'b0011101;  16: return 7'b1100111;  17: return 7'b1110011;
           18: return 7'b0000101;  19: return 7'b1011011;  20: return 7'b0001111;
           21: return 7'b0111110;  22: return 7'b0011100;  23: return 7'b0101010;
           24: return 7'b1001001;  25: return 7'b0111011;  26: return 7'b1101101;
           27: return 7'b0001000;
           default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 scroll, 2 pause; tick counts cycles since reset
    int         m_buf [D];
    int         m_len, m_off, m_mode, m_phase, m_pc, m_tick, m_idx, m_ch;
    logic [6:0] m_seg;
    logic [3:0] m_dig;
    logic       m_wrap;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int i = 0; i < D; i++) m_buf[i] = 31;
            m_len = 0; m_off = 0; m_mode = 0; m_phase = 0; m_pc = 0; m_tick = 0;
            m_seg = 7'b0; m_dig = 4'b0; m_wrap = 1'b0;
        end else begin
            m_idx = (m_tick / RD) % N;
            m_ch  = (m_len == 0) ? 31 : m_buf[(m_off + m_idx) % m_len];
            m_seg = ref_glyph(m_ch);
            m_dig = 4'(1 << m_idx);
            m_tick++;
            if (wr_en) m_buf[wr_addr] = int'(wr_char);
            m_wrap = 1'b0;
            if (stop) begin
                if (m_mode == 0) m_len = (msg_len > D) ? D : int'(msg_len);
                m_mode = 0; m_off = 0; m_phase = 0;
            end else begin
                case (m_mode)
                    0: begin
                        m_len = (msg_len > D) ? D : int'(msg_len);
                        if (start && msg_len != 0) begin m_mode = 1; m_phase = 0; end
                    end
                    1: begin
                        if (m_phase == SD - 1) begin
                            m_phase = 0;
                            m_off++;
                            if (m_off == m_len) begin
                                m_off = 0; m_wrap = 1'b1; m_mode = 2; m_pc = 0;
                            end
                        end else m_phase++;
                    end
                    default: begin
                        if (m_phase == SD - 1) begin
                            m_phase = 0;
                            m_pc++;
                            if (m_pc == PT) m_mode = 1;
                        end else m_phase++;
                    end
                endcase
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("seg", seg, m_seg);
            chk("dig_en", dig_en, m_dig);
            chk("busy", busy, m_mode != 0);
            chk("wrap_pulse", wrap_pulse, m_wrap);
            chk("seg_active_low", seg_n ^ m_seg, 7'h7F);
            chk("dig_en_active_low", dig_n ^ m_dig, 4'hF);
        end
    end

    task automatic write_char(input int addr, input int ch);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'(addr); wr_char = 5'(ch);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic p);
        @(negedge clk);
        start = s; stop = p;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    int  cnt;
    bit  seen;

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Static display of "HELP"
        write_char(0, 8); write_char(1, 5); write_char(2, 12); write_char(3, 16);
        msg_len = 5'd4;
        repeat (2) @(negedge clk);
        repeat (24) begin
            @(negedge clk);
            if (dig_en == 4'b0001) chk("static_h", seg, 7'b0110111);
            if (dig_en == 4'b0010) chk("static_e", seg, 7'b1001111);
            if (dig_en == 4'b0100) chk("static_l", seg, 7'b0001110);
            if (dig_en == 4'b1000) chk("static_p", seg, 7'b1100111);
        end

        // Scroll a 6-character message; first wrap 48 clocks after start
        write_char(4, 6); write_char(5, 15);
        msg_len = 5'd6;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (wrap_pulse !== 1'b1 && cnt < 200) begin
            @(posedge clk); #1; cnt++;
        end
        chk("wrap_latency", cnt, 48);
        chk("busy_at_wrap", busy, 1'b1);

        // Live write while scrolling
        write_char(1, 27);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (seg == 7'b0001000) seen = 1'b1;
        end
        chk("live_underbar_seen", seen, 1'b1);
        repeat (40) @(negedge clk);

        // start and stop together while scrolling: stop wins
        pulse(1'b1, 1'b1);
        chk("start_stop_idle", busy, 1'b0);
        msg_len = 5'd0;
        pulse(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("start_len0_idle", busy, 1'b0);

        // Short message repeats across digits
        write_char(0, 1); write_char(1, 2);
        msg_len = 5'd2;
        repeat (2) @(negedge clk);
        repeat (20) begin
            @(negedge clk);
            if (dig_en == 4'b0100) chk("short_a", seg, 7'b1110111);
            if (dig_en == 4'b1000) chk("short_b", seg, 7'b0011111);
        end
        pulse(1'b1, 1'b0);
        repeat (60) @(negedge clk);
        pulse(1'b0, 1'b1);
        msg_len = 5'd1;
        pulse(1'b1, 1'b0);
        repeat (60) @(negedge clk);
        pulse(1'b0, 1'b1);

        // Randomised traffic, including msg_len above MSG_DEPTH
        repeat (3000) begin
            @(negedge clk);
            wr_en   = ($urandom % 4) == 0;
            wr_addr = 4'($urandom);
            wr_char = 5'($urandom);
            start   = ($urandom % 40) == 0;
            stop    = ($urandom % 150) == 0;
            if (($urandom % 60) == 0) msg_len = 5'($urandom % 32);
        end
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0; stop = 1'b0;
        msg_len = 5'd4;

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_seg", seg, 7'b0000000);
        chk("rst_dig_en", dig_en, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_seg_n", seg_n, 7'b1111111);
        chk("rst_dig_n", dig_n, 4'b1111);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        repeat (16) begin
            @(negedge clk);
            chk("blank_after_rst", seg, 7'b0000000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_scroll_text_display
`default_nettype wire
